// File: rtl/ac_motor_pkg.sv
// Shared types for the multi-leg dead-time generator.
// Holds the per-leg state encoding and small decode helpers.
package ac_motor_pkg;

    localparam logic [2:0] ST_ALL_OFF      = 3'd0;
    localparam logic [2:0] ST_LOW_ON       = 3'd1;
    localparam logic [2:0] ST_DEAD_TO_HIGH = 3'd2;
    localparam logic [2:0] ST_HIGH_ON      = 3'd3;
    localparam logic [2:0] ST_DEAD_TO_LOW  = 3'd4;

    typedef enum logic [2:0] {
        ALL_OFF      = ST_ALL_OFF,
        LOW_ON       = ST_LOW_ON,
        DEAD_TO_HIGH = ST_DEAD_TO_HIGH,
        HIGH_ON      = ST_HIGH_ON,
        DEAD_TO_LOW  = ST_DEAD_TO_LOW
    } ch_state_e;

    function automatic logic is_dead(input ch_state_e s);
        return (s == DEAD_TO_HIGH) || (s == DEAD_TO_LOW);
    endfunction

endpackage

// File: rtl/ac_motor_deadtime_channel.sv
// One half-bridge leg: state machine plus dead-time down-counter.
// Gate outputs are registered decodes of the state, so they lag it by one edge.
module ac_motor_deadtime_channel
    import ac_motor_pkg::*;
#(
    parameter int DELAY_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [DELAY_W-1:0] delay_rise,
    input  logic [DELAY_W-1:0] delay_fall,
    input  logic               s_in,
    output logic               s_high,
    output logic               s_low,
    output logic               busy
);

    ch_state_e          state;
    logic [DELAY_W-1:0] cnt;
    logic               cnt_done;

    // A count of 0 or 1 both end the interval, giving max(D,1) cycles.
    assign cnt_done = (cnt <= DELAY_W'(1));
    assign busy     = is_dead(state);

    // Leg state, dead-time counter and registered gate drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ALL_OFF;
            cnt    <= '0;
            s_high <= 1'b0;
            s_low  <= 1'b0;
        end else begin
            s_high <= (state == HIGH_ON);
            s_low  <= (state == LOW_ON);
            if (!run) begin
                state <= ALL_OFF;
                cnt   <= '0;
            end else begin
                unique case (state)
                    ALL_OFF: begin
                        state <= s_in ? DEAD_TO_HIGH : DEAD_TO_LOW;
                        cnt   <= s_in ? delay_rise : delay_fall;
                    end
                    LOW_ON: begin
                        if (s_in) begin
                            state <= DEAD_TO_HIGH;
                            cnt   <= delay_rise;
                        end
                    end
                    HIGH_ON: begin
                        if (!s_in) begin
                            state <= DEAD_TO_LOW;
                            cnt   <= delay_fall;
                        end
                    end
                    DEAD_TO_HIGH: begin
                        if (!s_in) begin
                            state <= LOW_ON;
                            cnt   <= '0;
                        end else if (cnt_done) begin
                            state <= HIGH_ON;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    DEAD_TO_LOW: begin
                        if (s_in) begin
                            state <= HIGH_ON;
                            cnt   <= '0;
                        end else if (cnt_done) begin
                            state <= LOW_ON;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    default: begin
                        state <= ALL_OFF;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ac_motor_deadtime_multi.sv
// Multi-leg dead-time generator; one independent channel per bridge leg.
// Define AC_MOTOR_DT_FAULT_EN to add the latched fault_n shutdown path.
module ac_motor_deadtime_multi
    import ac_motor_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int DELAY_W  = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [DELAY_W-1:0]  delay_rise,
    input  logic [DELAY_W-1:0]  delay_fall,
    input  logic [CHANNELS-1:0] s_in,
    output logic [CHANNELS-1:0] s_high,
    output logic [CHANNELS-1:0] s_low,
`ifdef AC_MOTOR_DT_FAULT_EN
    output logic [CHANNELS-1:0] busy,
    input  logic                fault_n,
    output logic                fault_latched
`else
    output logic [CHANNELS-1:0] busy
`endif
);

    logic run;

`ifdef AC_MOTOR_DT_FAULT_EN
    logic fault_q;

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (!fault_n) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_latched = fault_q;
    // The sampling edge of a fault already parks every leg.
    assign run = enable & fault_n & ~fault_q;
`else
    assign run = enable;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ac_motor_deadtime_channel #(
            .DELAY_W(DELAY_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run),
            .delay_rise(delay_rise),
            .delay_fall(delay_fall),
            .s_in      (s_in[i]),
            .s_high    (s_high[i]),
            .s_low     (s_low[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_ac_motor_deadtime_multi.sv
// Self-checking bench for ac_motor_deadtime_multi.
// Reference model tracks each leg as a mode plus remaining dead cycles.
module tb_ac_motor_deadtime_multi;

    localparam int CH = 3;
    localparam int DW = 11;

    localparam int M_OFF  = 0;
    localparam int M_LOW  = 1;
    localparam int M_RISE = 2;
    localparam int M_HIGH = 3;
    localparam int M_FALL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] delay_rise;
    logic [DW-1:0] delay_fall;
    logic [CH-1:0] s_in;
    logic [CH-1:0] s_high;
    logic [CH-1:0] s_low;
    logic [CH-1:0] busy;
`ifdef AC_MOTOR_DT_FAULT_EN
    logic          fault_n;
    logic          fault_latched;
    logic          m_fault;
`endif

    int checks = 0;
    int errors = 0;

    int            st  [CH];
    int            rem [CH];
    logic [CH-1:0] e_high;
    logic [CH-1:0] e_low;
    logic [CH-1:0] e_busy;

    ac_motor_deadtime_multi #(
        .CHANNELS(CH),
        .DELAY_W (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .delay_rise   (delay_rise),
        .delay_fall   (delay_fall),
        .s_in         (s_in),
        .s_high       (s_high),
`ifdef AC_MOTOR_DT_FAULT_EN
        .s_low        (s_low),
        .busy         (busy),
        .fault_n      (fault_n),
        .fault_latched(fault_latched)
`else
        .s_low        (s_low),
        .busy         (busy)
`endif
    );

    always #5 clk = ~clk;

    // Shoot-through guard on every falling edge.
    always @(negedge clk) begin
        checks++;
        assert ((s_high & s_low) === '0)
        else begin
            errors++;
            $error("FAIL shoot_through high=%b low=%b want no overlap",
                   s_high, s_low);
        end
    end

    function automatic int dmax1(input logic [DW-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            st[i]  = M_OFF;
            rem[i] = 0;
        end
        e_high = '0;
        e_low  = '0;
        e_busy = '0;
`ifdef AC_MOTOR_DT_FAULT_EN
        m_fault = 1'b0;
`endif
    endtask

    task automatic model_edge();
        bit kill;
        int old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        kill = !enable;
`ifdef AC_MOTOR_DT_FAULT_EN
        if (!fault_n) m_fault = 1'b1;
        if (m_fault) kill = 1'b1;
`endif
        for (int i = 0; i < CH; i++) begin
            old       = st[i];
            e_high[i] = (old == M_HIGH);
            e_low[i]  = (old == M_LOW);
            if (kill) begin
                st[i] = M_OFF;
            end else begin
                case (old)
                    M_OFF: begin
                        st[i]  = s_in[i] ? M_RISE : M_FALL;
                        rem[i] = s_in[i] ? dmax1(delay_rise)
                                         : dmax1(delay_fall);
                    end
                    M_LOW: if (s_in[i]) begin
                        st[i]  = M_RISE;
                        rem[i] = dmax1(delay_rise);
                    end
                    M_HIGH: if (!s_in[i]) begin
                        st[i]  = M_FALL;
                        rem[i] = dmax1(delay_fall);
                    end
                    M_RISE: begin
                        if (!s_in[i]) st[i] = M_LOW;
                        else begin
                            rem[i]--;
                            if (rem[i] == 0) st[i] = M_HIGH;
                        end
                    end
                    M_FALL: begin
                        if (s_in[i]) st[i] = M_HIGH;
                        else begin
                            rem[i]--;
                            if (rem[i] == 0) st[i] = M_LOW;
                        end
                    end
                    default: st[i] = M_OFF;
                endcase
            end
            e_busy[i] = (st[i] == M_RISE) || (st[i] == M_FALL);
        end
    endtask

    task automatic check(input string tag);
        checks += 3;
        assert (s_high === e_high)
        else begin
            errors++;
            $error("FAIL %s s_high got %b want %b", tag, s_high, e_high);
        end
        assert (s_low === e_low)
        else begin
            errors++;
            $error("FAIL %s s_low got %b want %b", tag, s_low, e_low);
        end
        assert (busy === e_busy)
        else begin
            errors++;
            $error("FAIL %s busy got %b want %b", tag, busy, e_busy);
        end
`ifdef AC_MOTOR_DT_FAULT_EN
        checks++;
        assert (fault_latched === m_fault)
        else begin
            errors++;
            $error("FAIL %s fault_latched got %b want %b",
                   tag, fault_latched, m_fault);
        end
`endif
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check(tag);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        tick(n, "in_reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        s_in       = '0;
        delay_rise = DW'(15);
        delay_fall = DW'(10);
`ifdef AC_MOTOR_DT_FAULT_EN
        fault_n    = 1'b1;
`endif
        model_reset();
        #1;
        check("reset_state");
        tick(3, "reset_hold");
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(15, "startup_low");

        // Basic rise on leg 0 with 15-cycle dead time.
        s_in[0] = 1'b1;
        tick(20, "basic_rise");

        // Asymmetric fall with 10-cycle dead time.
        s_in[0] = 1'b0;
        tick(15, "asym_fall");

        // Short request on leg 1 never reaches high side.
        delay_rise = DW'(20);
        s_in[1] = 1'b1;
        tick(5, "glitch_hi");
        s_in[1] = 1'b0;
        tick(25, "glitch_revert");

        // Delay change mid-interval only affects the next entry.
        delay_rise = DW'(15);
        s_in[2] = 1'b1;
        tick(5, "mid_change_a");
        delay_rise = DW'(10);
        tick(15, "mid_change_b");
        s_in[2] = 1'b0;
        tick(15, "mid_change_fall");
        s_in[2] = 1'b1;
        tick(15, "mid_change_next");

        // Disable while leg 2 is high, then re-enable.
        enable = 1'b0;
        tick(3, "disable");
        enable = 1'b1;
        tick(15, "reenable");

        // Reset pulse while leg 2 is high.
        do_reset(2);
        tick(15, "post_reset");

        // Zero delays behave as one-cycle dead time.
        delay_rise = '0;
        delay_fall = '0;
        for (int k = 0; k < 6; k++) begin
            s_in = CH'(k);
            tick(3, "zero_delay");
        end

        // Full-scale delay on leg 0.
        delay_fall = DW'(3);
        delay_rise = '1;
        s_in = '0;
        tick(10, "max_prep");
        s_in[0] = 1'b1;
        tick(2060, "max_delay");

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if (k % 40 == 0) begin
                delay_rise = DW'($urandom_range(0, 12));
                delay_fall = DW'($urandom_range(0, 12));
            end
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 7) == 0) s_in[i] = ~s_in[i];
            end
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 599) == 0) do_reset(2);
            tick(1, "random");
        end
        enable = 1'b1;

`ifdef AC_MOTOR_DT_FAULT_EN
        delay_rise = DW'(4);
        delay_fall = DW'(4);
        tick(10, "fault_prep");
        fault_n = 1'b0;
        tick(1, "fault_pulse");
        fault_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_in = CH'($urandom_range(0, 7));
            tick(3, "fault_hold");
        end
        do_reset(2);
        tick(15, "fault_cleared");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_motor_deadtime_multi.md
AC_MOTOR_DEADTIME_MULTI -- requirements
Module: ac_motor_deadtime_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent half-bridge legs.
REQ-002 SHALL have parameter DELAY_W, default 11: width of the dead-time counters and delay inputs.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: global bridge enable.
REQ-006 SHALL have port delay_rise, input, DELAY_W bits: dead-time cycles before any high-side turn-on.
REQ-007 SHALL have port delay_fall, input, DELAY_W bits: dead-time cycles before any low-side turn-on.
REQ-008 SHALL have port s_in, input, CHANNELS bits: requested leg state per channel (1 = high side on).
REQ-009 SHALL have port s_high, output, CHANNELS bits: high-side gate drive.
REQ-010 SHALL have port s_low, output, CHANNELS bits: low-side gate drive.
REQ-011 SHALL have port busy, output, CHANNELS bits: 1 while the channel is in a dead-time state.

Function
REQ-012 SHALL run one independent four-state FSM per channel: LOW_ON, DEAD_TO_HIGH, HIGH_ON, DEAD_TO_LOW, plus ALL_OFF.
REQ-013 SHALL drive outputs from registers: LOW_ON gives s_low=1/s_high=0, HIGH_ON gives s_high=1/s_low=0, and all other states give both 0.
REQ-014 SHALL never assert s_high[i] and s_low[i] in the same cycle, under any input sequence.
REQ-015 SHALL, in LOW_ON, on sampling s_in[i]=1, enter DEAD_TO_HIGH and load the counter with delay_rise; s_low falls one cycle after the sampling edge.
REQ-016 SHALL, in HIGH_ON, on sampling s_in[i]=0, enter DEAD_TO_LOW and load the counter with delay_fall.
REQ-017 SHALL keep both outputs 0 in a dead state for exactly max(D,1) cycles, where D is the delay value latched on entry, then enter the target ON state.
REQ-018 SHALL ignore delay_rise and delay_fall changes during a dead interval; new values take effect at the next entry.
REQ-019 SHALL, if s_in[i] reverts during DEAD_TO_HIGH, return to LOW_ON on the next edge; DEAD_TO_LOW reverts symmetrically to HIGH_ON.
REQ-020 SHALL, when enable=0, force every channel to ALL_OFF on the next edge, regardless of state.
REQ-021 SHALL, in ALL_OFF with enable=1, enter DEAD_TO_HIGH (s_in=1) or DEAD_TO_LOW (s_in=0) and serve the full delay before turning anything on.
REQ-022 SHALL decrement the counter to zero only, with no wrap-around; a DELAY_W all-ones value gives 2^DELAY_W-1 cycles.
REQ-023 SHALL assert busy[i] exactly while channel i is in DEAD_TO_HIGH or DEAD_TO_LOW.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force all channels to ALL_OFF, s_high=0, s_low=0, busy=0, and all counters to 0.
REQ-025 SHALL, after rst_n rises mid-operation, resume through the ALL_OFF path of REQ-021; no output turns on without a full dead interval.

Configuration
REQ-026 SHALL, with macro AC_MOTOR_DT_FAULT_EN defined, add input fault_n (active-low, 1 bit) and output fault_latched (1 bit).
REQ-027 SHALL, with AC_MOTOR_DT_FAULT_EN defined, treat fault_n=0 sampled on any edge as follows: set fault_latched, force all channels to ALL_OFF on the next edge, and hold them there until reset, even if enable=1.
REQ-028 SHALL, without AC_MOTOR_DT_FAULT_EN, omit both fault ports and all fault logic; behaviour is otherwise identical.

Structure
REQ-029 SHALL place the channel-state enum and state encodings in shared package ac_motor_pkg.
REQ-030 SHALL implement the per-channel FSM and counter as sub-module ac_motor_deadtime_channel, instantiated CHANNELS times by a generate loop.

Verification
REQ-031 Basic rise: delay_rise=15, enable=1, s_in[0] 0->1 at edge k -> s_low[0] falls at k+1, both 0 for 15 cycles, s_high[0] rises at k+16.
REQ-032 Asymmetric: delay_fall=10, s_in[0] 1->0 -> both outputs 0 for exactly 10 cycles, then s_low[0]=1.
REQ-033 Glitch revert: delay_rise=20, s_in[1] pulses high for 5 cycles -> s_high[1] never asserts and s_low[1] returns 1 cycle after s_in[1] falls.
REQ-034 Mid-interval delay change: delay_rise changes 15->10 during a dead interval -> the current interval stays 15 cycles and the next one is 10.
REQ-035 Enable/reset: deassert enable, or pulse rst_n low, while channel 2 is HIGH_ON -> outputs 0, and re-enable gives the full delay before turn-on.
REQ-036 Fault (macro defined): fault_n low for 1 cycle -> fault_latched=1 and all outputs 0 until rst_n; a shoot-through assertion is checked across all tests.
